// File: rtl/paralelo_serial_tx.sv
// Purpose: byte FIFO feeding an MSB-first serializer. After reset it sends TRAIN_COUNT commas, then FIFO data or idle commas.
// Latency: a byte pushed into an empty FIFO while ACTIVE goes out at the next load edge strictly after the push, as 8 bit cycles.
// Backpressure: ready_out is low while the FIFO is full and in the first cycle after reset; valid_in is ignored while it is low.
// Ports: clk_32f bit clock; reset sync active-high; data_in/valid_in/ready_out byte push handshake;
//        data_out serial line; byte_start_out marks bit 7; data_sym_out marks FIFO symbols; active_out marks training done.
module paralelo_serial_tx #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned TRAIN_COUNT = 4,
    parameter int unsigned FIFO_AW     = 2
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_start_out,
    output logic       data_sym_out,
    output logic       active_out
);

    localparam int unsigned      DEPTH      = 1 << FIFO_AW;
    localparam int unsigned      CNT_W      = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [3:0]       TRAIN_LAST = 4'(TRAIN_COUNT);

    typedef enum logic {ST_TRAIN, ST_ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         train_cnt_q, train_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               data_out_q, data_out_d;
    logic               byte_start_q, byte_start_d;
    logic               data_sym_q, data_sym_d;
    logic               active_q, active_d;
    logic               reset_q, reset_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         fifo_mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic [7:0]         sym;
    logic               sym_from_fifo;

    // reset_q holds ready_out low for one cycle after release so the
    // upstream never sees a ready that was computed from pre-reset state.
    assign ready_out      = !reset_q && (count_q != CNT_FULL);
    assign push           = valid_in && ready_out && !reset;
    assign data_out       = data_out_q;
    assign byte_start_out = byte_start_q;
    assign data_sym_out   = data_sym_q;
    assign active_out     = active_q;

    always_comb begin
        bit_cnt_d     = bit_cnt_q + 3'd1;
        shift_d       = {shift_q[6:0], 1'b0};
        data_out_d    = shift_q[7];
        byte_start_d  = 1'b0;
        data_sym_d    = data_sym_q;
        state_d       = state_q;
        train_cnt_d   = train_cnt_q;
        active_d      = active_q;
        reset_d       = 1'b0;
        pop           = 1'b0;
        sym           = COMMA;
        sym_from_fifo = 1'b0;

        if (bit_cnt_q == 3'd0) begin
            if (state_q == ST_TRAIN) begin
                // The comma sent on this edge is itself the last training symbol.
                train_cnt_d = train_cnt_q + 4'd1;
                if (train_cnt_d == TRAIN_LAST) begin
                    state_d  = ST_ACTIVE;
                    active_d = 1'b1;
                end
            end else if (count_q != '0) begin
                // Uses the pre-edge count, so a byte pushed on this very
                // edge waits for the following load edge.
                pop           = 1'b1;
                sym           = fifo_mem_q[rd_ptr_q];
                sym_from_fifo = 1'b1;
            end
            data_out_d   = sym[7];
            shift_d      = {sym[6:0], 1'b0};
            byte_start_d = 1'b1;
            data_sym_d   = sym_from_fifo;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q      <= ST_TRAIN;
            train_cnt_q  <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 1'b0;
            byte_start_q <= 1'b0;
            data_sym_q   <= 1'b0;
            active_q     <= 1'b0;
            reset_q      <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            byte_start_q <= byte_start_d;
            data_sym_q   <= data_sym_d;
            active_q     <= active_d;
            reset_q      <= reset_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_32f) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
module tb_paralelo_serial_tx;

    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, byte_start_out, data_sym_out, active_out;

    logic       reset2 = 1'b1;
    logic [7:0] data_in2 = 8'd0;
    logic       valid_in2 = 1'b0;
    logic       ready_out2, data_out2, byte_start_out2, data_sym_out2, active_out2;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    paralelo_serial_tx dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .byte_start_out(byte_start_out),
        .data_sym_out(data_sym_out), .active_out(active_out)
    );

    paralelo_serial_tx #(.COMMA(8'hBC), .TRAIN_COUNT(1), .FIFO_AW(3)) dut2 (
        .clk_32f(clk_32f), .reset(reset2), .data_in(data_in2), .valid_in(valid_in2),
        .ready_out(ready_out2), .data_out(data_out2), .byte_start_out(byte_start_out2),
        .data_sym_out(data_sym_out2), .active_out(active_out2)
    );

    // Outputs are sampled 1 time unit after each rising edge; inputs set
    // there take effect at the next edge. edge_n counts edges since release.
    task automatic tick();
        @(posedge clk_32f);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (3) tick();
        n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset data_out: got %b expected 0", data_out); end
        n_checks++; if (byte_start_out !== 1'b0) begin n_fail++; $display("FAIL reset byte_start_out: got %b expected 0", byte_start_out); end
        n_checks++; if (data_sym_out !== 1'b0) begin n_fail++; $display("FAIL reset data_sym_out: got %b expected 0", data_sym_out); end
        n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL reset active_out: got %b expected 0", active_out); end
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset ready_out: got %b expected 0", ready_out); end
        reset = 1'b0;
        edge_n = 0;
        #1;
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL release ready_out: got %b expected 0", ready_out); end
        tick();
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL post-release ready_out: got %b expected 1", ready_out); end
    endtask

    task automatic test_training();
        logic [7:0] sym;
        int ph;
        do_reset();
        repeat (64) begin
            tick();
            ph  = (edge_n - 1) % 8;
            sym = 8'hBC;
            n_checks++; if (data_out !== sym[7-ph]) begin n_fail++; $display("FAIL training data_out edge %0d: got %b expected %b", edge_n, data_out, sym[7-ph]); end
            n_checks++; if (byte_start_out !== (ph == 0)) begin n_fail++; $display("FAIL training byte_start edge %0d: got %b expected %b", edge_n, byte_start_out, ph == 0); end
            n_checks++; if (data_sym_out !== 1'b0) begin n_fail++; $display("FAIL training data_sym edge %0d: got %b expected 0", edge_n, data_sym_out); end
            n_checks++; if (active_out !== (edge_n >= 25)) begin n_fail++; $display("FAIL training active edge %0d: got %b expected %b", edge_n, active_out, edge_n >= 25); end
        end
    endtask

    task automatic test_train_push();
        logic [7:0] sym;
        int ph;
        logic exp_dat;
        do_reset();
        while (edge_n < 48) begin
            valid_in = (edge_n + 1 == 3);
            data_in  = (edge_n + 1 == 3) ? 8'h5A : 8'hFF;
            tick();
            ph      = (edge_n - 1) % 8;
            exp_dat = (edge_n >= 33 && edge_n <= 40);
            sym     = exp_dat ? 8'h5A : 8'hBC;
            n_checks++; if (data_out !== sym[7-ph]) begin n_fail++; $display("FAIL train_push data_out edge %0d: got %b expected %b", edge_n, data_out, sym[7-ph]); end
            n_checks++; if (data_sym_out !== exp_dat) begin n_fail++; $display("FAIL train_push data_sym edge %0d: got %b expected %b", edge_n, data_sym_out, exp_dat); end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sym;
        int ph, idx, nxt;
        logic pushed;
        do_reset();
        repeat (27) tick();
        nxt = 1;
        valid_in = 1'b1;
        data_in = 8'd1;
        while (edge_n < 88) begin
            pushed = valid_in && ready_out;
            tick();
            if (pushed) begin
                nxt++;
                if (nxt > 6) valid_in = 1'b0;
                else data_in = 8'(nxt);
            end
            if (edge_n == 31 || edge_n == 33 || edge_n == 34 || edge_n == 42) begin
                n_checks++; if (ready_out !== (edge_n == 33)) begin n_fail++; $display("FAIL b2b ready_out edge %0d: got %b expected %b", edge_n, ready_out, edge_n == 33); end
            end
            if (edge_n >= 33) begin
                idx = (edge_n - 33) / 8;
                ph  = (edge_n - 33) % 8;
                sym = (idx < 6) ? 8'(idx + 1) : 8'hBC;
                n_checks++; if (data_out !== sym[7-ph]) begin n_fail++; $display("FAIL b2b data_out edge %0d: got %b expected %b", edge_n, data_out, sym[7-ph]); end
                n_checks++; if (byte_start_out !== (ph == 0)) begin n_fail++; $display("FAIL b2b byte_start edge %0d: got %b expected %b", edge_n, byte_start_out, ph == 0); end
                n_checks++; if (data_sym_out !== (idx < 6)) begin n_fail++; $display("FAIL b2b data_sym edge %0d: got %b expected %b", edge_n, data_sym_out, idx < 6); end
            end
        end
        valid_in = 1'b0;
    endtask

    // Continues from test_back_to_back: FIFO empty, edge 89 is a load edge.
    task automatic test_push_on_load();
        logic [7:0] exp_sym [8] = '{8'hBC, 8'h77, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hBC};
        logic [7:0] sym;
        int ph, idx;
        while (edge_n < 152) begin
            valid_in = 1'b1;
            case (edge_n + 1)
                89:      data_in = 8'h77;
                98:      data_in = 8'hA1;
                99:      data_in = 8'hA2;
                105:     data_in = 8'hA3;
                106:     data_in = 8'hA4;
                107:     data_in = 8'hA5;
                default: valid_in = 1'b0;
            endcase
            tick();
            idx = (edge_n - 89) / 8;
            ph  = (edge_n - 89) % 8;
            sym = exp_sym[idx];
            n_checks++; if (data_out !== sym[7-ph]) begin n_fail++; $display("FAIL push_on_load data_out edge %0d: got %b expected %b", edge_n, data_out, sym[7-ph]); end
            n_checks++; if (data_sym_out !== (idx >= 1 && idx <= 6)) begin n_fail++; $display("FAIL push_on_load data_sym edge %0d: got %b expected %b", edge_n, data_sym_out, idx >= 1 && idx <= 6); end
            if (edge_n == 106 || edge_n == 107) begin
                n_checks++; if (ready_out !== (edge_n == 106)) begin n_fail++; $display("FAIL push_pop count ready_out edge %0d: got %b expected %b", edge_n, ready_out, edge_n == 106); end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_symbol();
        logic [7:0] sym;
        int ph;
        logic exp_dat;
        do_reset();
        while (edge_n < 36) begin
            valid_in = (edge_n + 1 >= 28 && edge_n + 1 <= 31);
            data_in  = 8'(17 * (edge_n + 1 - 27));
            tick();
            if (edge_n >= 33) begin
                n_checks++; if (data_sym_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset pre data_sym edge %0d: got %b expected 1", edge_n, data_sym_out); end
            end
        end
        reset = 1'b1;
        valid_in = 1'b0;
        tick();
        n_checks++; if ({data_out, byte_start_out, data_sym_out, active_out, ready_out} !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset outputs: got %b expected 00000", {data_out, byte_start_out, data_sym_out, active_out, ready_out}); end
        repeat (2) tick();
        reset = 1'b0;
        edge_n = 0;
        while (edge_n < 40) begin
            valid_in = (edge_n + 1 == 26);
            data_in  = 8'h99;
            tick();
            ph      = (edge_n - 1) % 8;
            exp_dat = (edge_n >= 33);
            sym     = exp_dat ? 8'h99 : 8'hBC;
            n_checks++; if (data_out !== sym[7-ph]) begin n_fail++; $display("FAIL mid_reset data_out edge %0d: got %b expected %b", edge_n, data_out, sym[7-ph]); end
            n_checks++; if (data_sym_out !== exp_dat) begin n_fail++; $display("FAIL mid_reset data_sym edge %0d: got %b expected %b", edge_n, data_sym_out, exp_dat); end
            n_checks++; if (active_out !== (edge_n >= 25)) begin n_fail++; $display("FAIL mid_reset active edge %0d: got %b expected %b", edge_n, active_out, edge_n >= 25); end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_params();
        logic [7:0] sym;
        int ph;
        reset2 = 1'b1;
        valid_in2 = 1'b0;
        repeat (3) tick();
        n_checks++; if (active_out2 !== 1'b0) begin n_fail++; $display("FAIL params reset active: got %b expected 0", active_out2); end
        reset2 = 1'b0;
        edge_n = 0;
        while (edge_n < 24) begin
            valid_in2 = (edge_n + 1 >= 2 && edge_n + 1 <= 10);
            data_in2  = 8'(16 + edge_n - 1);
            tick();
            ph  = (edge_n - 1) % 8;
            sym = (edge_n < 9) ? 8'hBC : ((edge_n < 17) ? 8'h10 : 8'h11);
            n_checks++; if (active_out2 !== 1'b1) begin n_fail++; $display("FAIL params active edge %0d: got %b expected 1", edge_n, active_out2); end
            n_checks++; if (data_out2 !== sym[7-ph]) begin n_fail++; $display("FAIL params data_out edge %0d: got %b expected %b", edge_n, data_out2, sym[7-ph]); end
            n_checks++; if (data_sym_out2 !== (edge_n >= 9)) begin n_fail++; $display("FAIL params data_sym edge %0d: got %b expected %b", edge_n, data_sym_out2, edge_n >= 9); end
            if (edge_n >= 2 && edge_n <= 10) begin
                n_checks++; if (ready_out2 !== (edge_n != 10)) begin n_fail++; $display("FAIL params ready_out edge %0d: got %b expected %b", edge_n, ready_out2, edge_n != 10); end
            end
        end
        valid_in2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_training();
        test_train_push();
        test_back_to_back();
        test_push_on_load();
        test_reset_mid_symbol();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
